// File: rtl/fp_pkg.sv
// Shared floating-point definitions: default bf16 widths, bias and canonical qNaN helpers,
// operand class encoding and sticky exception flag bit positions.
package fp_pkg;
  localparam int FP_EXP_W = 8;
  localparam int FP_MAN_W = 7;

  localparam int FLG_INVALID   = 3;
  localparam int FLG_OVERFLOW  = 2;
  localparam int FLG_UNDERFLOW = 1;
  localparam int FLG_INEXACT   = 0;

  typedef enum logic [1:0] {ZERO, NORM, INF, NAN} fp_class_e;

  function automatic int fp_bias(input int exp_w);
    return (1 << (exp_w - 1)) - 1;
  endfunction

  // Canonical quiet NaN: sign 0, exponent all ones, only the fraction MSB set.
  function automatic logic [63:0] fp_qnan(input int exp_w, input int man_w);
    return (((64'd1 << exp_w) - 64'd1) << man_w) | (64'd1 << (man_w - 1));
  endfunction
endpackage

// File: rtl/fp_mul_round.sv
// Normalise, round (FPMUL_RNE_EN: nearest-even, else truncate), range check and pack.
// Latency: combinational, no state.
// Backpressure: none; the enclosing pipeline registers the result and stalls around it.
module fp_mul_round import fp_pkg::*; #(
  parameter int EXP_W = FP_EXP_W,
  parameter int MAN_W = FP_MAN_W,
  localparam int W  = 1 + EXP_W + MAN_W,
  localparam int PW = 2 * (MAN_W + 1),
  localparam int EW = EXP_W + 2
) (
  input  fp_class_e            i_cls,
  input  logic                 i_sign,
  input  logic                 i_invalid,
  input  logic signed [EW-1:0] i_exp,
  input  logic [PW-1:0]        i_prod,
  output logic [W-1:0]         o_p,
  output logic [3:0]           o_flags
);
  localparam logic [63:0]          QNAN64   = fp_qnan(EXP_W, MAN_W);
  localparam logic signed [EW-1:0] EXP_MAX  = EW'((1 << EXP_W) - 1);
  localparam logic signed [EW-1:0] EXP_ZERO = '0;

  logic [PW-2:0]        w_norm;
  logic signed [EW-1:0] w_exp_n;
  logic [MAN_W-1:0]     w_frac;
  logic                 w_g;
  logic                 w_r;
  logic                 w_s;
  logic                 w_inexact;
  logic [MAN_W-1:0]     w_frac_r;
  logic signed [EW-1:0] w_exp_r;

  // Leading one dropped: w_norm is the stored fraction followed by every bit below it.
  assign w_norm    = i_prod[PW-1] ? i_prod[PW-2:0] : {i_prod[PW-3:0], 1'b0};
  assign w_exp_n   = i_prod[PW-1] ? i_exp + EW'(1) : i_exp;
  assign w_frac    = w_norm[PW-2 -: MAN_W];
  assign w_g       = w_norm[MAN_W];
  assign w_r       = w_norm[MAN_W-1];
  assign w_s       = |w_norm[MAN_W-2:0];
  assign w_inexact = w_g | w_r | w_s;

`ifdef FPMUL_RNE_EN
  logic [MAN_W:0] w_frac_inc;
  logic           w_up;

  assign w_up       = w_g & (w_r | w_s | w_frac[0]);
  assign w_frac_inc = {1'b0, w_frac} + {{MAN_W{1'b0}}, w_up};
  // A carry out leaves the fraction at zero (mantissa 1.0); only the exponent moves.
  assign w_frac_r   = w_frac_inc[MAN_W-1:0];
  assign w_exp_r    = w_exp_n + $signed(EW'({1'b0, w_frac_inc[MAN_W]}));
`else
  assign w_frac_r   = w_frac;
  assign w_exp_r    = w_exp_n;
`endif

  always_comb begin
    o_p     = '0;
    o_flags = '0;
    unique case (i_cls)
      NAN:  o_p = QNAN64[W-1:0];
      INF:  o_p = {i_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      ZERO: o_p = {i_sign, {(W-1){1'b0}}};
      default: begin
        if (w_exp_r >= EXP_MAX) begin
          o_p = {i_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
          o_flags[FLG_OVERFLOW] = 1'b1;
          o_flags[FLG_INEXACT]  = 1'b1;
        end else if (w_exp_r <= EXP_ZERO) begin
          // Product of two normals is never exactly zero, so flushing is always inexact.
          o_p = {i_sign, {(W-1){1'b0}}};
          o_flags[FLG_UNDERFLOW] = 1'b1;
          o_flags[FLG_INEXACT]   = 1'b1;
        end else begin
          o_p = {i_sign, w_exp_r[EXP_W-1:0], w_frac_r};
          o_flags[FLG_INEXACT] = w_inexact;
        end
      end
    endcase
    o_flags[FLG_INVALID] = i_invalid;
  end
endmodule

// File: rtl/fp_mul_pipe.sv
// 3-stage pipelined FP multiplier (unpack/exp sum, mantissa product, round/pack), sticky flags, tag sideband.
// Latency: 3 cycles handshake-to-result, 1 result per cycle; FPMUL_RNE_EN selects round-to-nearest-even.
// Backpressure: the whole pipe advances only when the output register is empty or accepted; in_ready = advance.
module fp_mul_pipe import fp_pkg::*; #(
  parameter int EXP_W = FP_EXP_W,
  parameter int MAN_W = FP_MAN_W,
  parameter int TAG_W = 4,
  localparam int W  = 1 + EXP_W + MAN_W,
  localparam int PW = 2 * (MAN_W + 1),
  localparam int EW = EXP_W + 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     in_a,
  input  logic [W-1:0]     in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_p,
  output logic [TAG_W-1:0] out_tag,
  output logic [3:0]       flags,
  input  logic             clr_flags
);
  function automatic fp_class_e classify(input logic [EXP_W-1:0] e, input logic [MAN_W-1:0] f);
    if (&e) return (|f) ? NAN : INF;
    if (e == '0) return ZERO;
    return NORM;
  endfunction

  logic                 w_advance;
  logic                 w_out_hs;
  fp_class_e            w_a_cls;
  fp_class_e            w_b_cls;
  fp_class_e            w_cls;
  logic                 w_invalid;
  logic signed [EW-1:0] w_exp_sum;
  logic [W-1:0]         w_rnd_p;
  logic [3:0]           w_rnd_flags;

  logic                 r_s1_vld;
  fp_class_e            r_s1_cls;
  logic                 r_s1_inv;
  logic                 r_s1_sign;
  logic signed [EW-1:0] r_s1_exp;
  logic [MAN_W:0]       r_s1_ma;
  logic [MAN_W:0]       r_s1_mb;
  logic [TAG_W-1:0]     r_s1_tag;

  logic                 r_s2_vld;
  fp_class_e            r_s2_cls;
  logic                 r_s2_inv;
  logic                 r_s2_sign;
  logic signed [EW-1:0] r_s2_exp;
  logic [PW-1:0]        r_s2_prod;
  logic [TAG_W-1:0]     r_s2_tag;

  logic                 r_out_vld;
  logic [W-1:0]         r_out_p;
  logic [TAG_W-1:0]     r_out_tag;
  logic [3:0]           r_out_flags;
  logic [3:0]           r_flags;

  assign w_advance = out_ready | ~r_out_vld;
  assign w_out_hs  = r_out_vld & out_ready;
  assign in_ready  = w_advance;
  assign out_valid = r_out_vld;
  assign out_p     = r_out_p;
  assign out_tag   = r_out_tag;
  assign flags     = r_flags;

  assign w_a_cls   = classify(in_a[W-2 -: EXP_W], in_a[MAN_W-1:0]);
  assign w_b_cls   = classify(in_b[W-2 -: EXP_W], in_b[MAN_W-1:0]);
  assign w_exp_sum = $signed({2'b00, in_a[W-2 -: EXP_W]}) + $signed({2'b00, in_b[W-2 -: EXP_W]})
                   - EW'(fp_bias(EXP_W));

  // Special cases resolved up front so later stages only carry a result class.
  always_comb begin
    w_cls     = NORM;
    w_invalid = 1'b0;
    if (w_a_cls == NAN || w_b_cls == NAN) begin
      w_cls = NAN;
    end else if ((w_a_cls == INF && w_b_cls == ZERO) || (w_a_cls == ZERO && w_b_cls == INF)) begin
      w_cls     = NAN;
      w_invalid = 1'b1;
    end else if (w_a_cls == INF || w_b_cls == INF) begin
      w_cls = INF;
    end else if (w_a_cls == ZERO || w_b_cls == ZERO) begin
      w_cls = ZERO;
    end
  end

  always_ff @(posedge clk) begin
    if (w_advance) begin
      r_s1_cls  <= w_cls;
      r_s1_inv  <= w_invalid;
      r_s1_sign <= in_a[W-1] ^ in_b[W-1];
      r_s1_exp  <= w_exp_sum;
      r_s1_ma   <= {1'b1, in_a[MAN_W-1:0]};
      r_s1_mb   <= {1'b1, in_b[MAN_W-1:0]};
      r_s1_tag  <= in_tag;

      r_s2_cls  <= r_s1_cls;
      r_s2_inv  <= r_s1_inv;
      r_s2_sign <= r_s1_sign;
      r_s2_exp  <= r_s1_exp;
      r_s2_prod <= PW'(r_s1_ma) * PW'(r_s1_mb);
      r_s2_tag  <= r_s1_tag;
    end
  end

  fp_mul_round #(
    .EXP_W (EXP_W),
    .MAN_W (MAN_W)
  ) u_round (
    .i_cls     (r_s2_cls),
    .i_sign    (r_s2_sign),
    .i_invalid (r_s2_inv),
    .i_exp     (r_s2_exp),
    .i_prod    (r_s2_prod),
    .o_p       (w_rnd_p),
    .o_flags   (w_rnd_flags)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_vld    <= 1'b0;
      r_s2_vld    <= 1'b0;
      r_out_vld   <= 1'b0;
      r_out_p     <= '0;
      r_out_tag   <= '0;
      r_out_flags <= '0;
      r_flags     <= '0;
    end else begin
      if (w_advance) begin
        r_s1_vld  <= in_valid;
        r_s2_vld  <= r_s1_vld;
        r_out_vld <= r_s2_vld;
        if (r_s2_vld) begin
          r_out_p     <= w_rnd_p;
          r_out_tag   <= r_s2_tag;
          r_out_flags <= w_rnd_flags;
        end
      end
      // A flag raised by this cycle's handshake survives a simultaneous clear.
      r_flags <= (clr_flags ? 4'b0000 : r_flags) | (w_out_hs ? r_out_flags : 4'b0000);
    end
  end
endmodule

// File: tb/tb_fp_mul_pipe.sv
// Randomized and directed bench for fp_mul_pipe (bf16 defaults) against an integer-arithmetic reference.
// Honours FPMUL_RNE_EN the same way as the design build.
module tb_fp_mul_pipe;
  localparam int TAG_W = 4;
  localparam int W     = 16;

`ifdef FPMUL_RNE_EN
  localparam logic [15:0] EXP_3FC1_SQ = 16'h4012;
  localparam logic [15:0] EXP_3FB5_SQ = 16'h4000;
`else
  localparam logic [15:0] EXP_3FC1_SQ = 16'h4011;
  localparam logic [15:0] EXP_3FB5_SQ = 16'h3FFF;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     in_a;
  logic [W-1:0]     in_b;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [W-1:0]     out_p;
  logic [TAG_W-1:0] out_tag;
  logic [3:0]       flags;
  logic             clr_flags;

  always #5 clk = ~clk;

  fp_mul_pipe dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_p     (out_p),
    .out_tag   (out_tag),
    .flags     (flags),
    .clr_flags (clr_flags)
  );

  typedef struct packed {
    logic [15:0] p;
    logic [3:0]  tag;
    logic [3:0]  fl;
  } exp_t;

  exp_t       sb_q[$];
  logic [3:0] m_flags = 4'b0000;
  int         checks   = 0;
  int         failures = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  // Reference: exact integer product, then rounding decided from the discarded remainder.
  function automatic void ref_mul(input logic [15:0] a, input logic [15:0] b,
                                  output logic [15:0] p, output logic [3:0] fl);
    int     ea, eb, e, sh;
    longint prod, q, rem, half;
    logic   s;
    bit     a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    ea = int'(a[14:7]);
    eb = int'(b[14:7]);
    s  = a[15] ^ b[15];
    a_nan  = (ea == 255) && (a[6:0] != 0);
    b_nan  = (eb == 255) && (b[6:0] != 0);
    a_inf  = (ea == 255) && (a[6:0] == 0);
    b_inf  = (eb == 255) && (b[6:0] == 0);
    a_zero = (ea == 0);
    b_zero = (eb == 0);
    fl = 4'b0000;
    p  = 16'h0000;
    if (a_nan || b_nan) begin
      p = 16'h7FC0;
    end else if ((a_inf && b_zero) || (a_zero && b_inf)) begin
      p  = 16'h7FC0;
      fl = 4'b1000;
    end else if (a_inf || b_inf) begin
      p = {s, 15'h7F80};
    end else if (a_zero || b_zero) begin
      p = {s, 15'h0000};
    end else begin
      prod = longint'(128 + int'(a[6:0])) * longint'(128 + int'(b[6:0]));
      e    = ea + eb - 127;
      if (prod >= 32768) begin
        sh = 8;
        e++;
      end else begin
        sh = 7;
      end
      q    = prod >> sh;
      rem  = prod - (q << sh);
      half = longint'(1) << (sh - 1);
`ifdef FPMUL_RNE_EN
      if (rem > half || (rem == half && (q % 2) == 1)) q++;
      if (q == 256) begin
        q = 128;
        e++;
      end
`endif
      if (rem != 0) fl[0] = 1'b1;
      if (e >= 255) begin
        p  = {s, 15'h7F80};
        fl = 4'b0101;
      end else if (e <= 0) begin
        p  = {s, 15'h0000};
        fl = 4'b0011;
      end else begin
        p = {s, e[7:0], q[6:0]};
      end
    end
  endfunction

  function automatic logic [15:0] gen_op();
    logic [7:0] e;
    logic [6:0] f;
    logic       s;
    s = 1'($urandom);
    f = 7'($urandom);
    case ($urandom % 8)
      0: e = 8'd0;
      1: begin e = 8'hFF; f = 7'd0; end
      2: begin e = 8'hFF; f = 7'($urandom_range(1, 127)); end
      3: e = 8'($urandom_range(190, 254));
      4: e = 8'($urandom_range(1, 64));
      default: e = 8'($urandom_range(100, 154));
    endcase
    return {s, e, f};
  endfunction

  // One clock: drive at negedge, note handshakes just before the posedge, check flags after it.
  task automatic step(input logic v, input logic [15:0] a, input logic [15:0] b, input logic [3:0] t,
                      input logic ordy, input logic clr, input logic r);
    exp_t       e;
    logic [15:0] p;
    logic [3:0]  fl;
    logic [3:0]  set_fl;
    in_valid  = v;
    in_a      = a;
    in_b      = b;
    in_tag    = t;
    out_ready = ordy;
    clr_flags = clr;
    rst       = r;
    set_fl    = 4'b0000;
    #1;
    if (!r) begin
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_out", out_valid, 1'b0);
        end else begin
          e = sb_q.pop_front();
          chk("out_p", out_p, e.p);
          chk("out_tag", out_tag, e.tag);
          set_fl = e.fl;
        end
      end
      if (in_valid && in_ready) begin
        ref_mul(a, b, p, fl);
        sb_q.push_back({p, t, fl});
      end
    end
    @(posedge clk);
    if (r) begin
      m_flags = 4'b0000;
      sb_q.delete();
    end else begin
      m_flags = (clr ? 4'b0000 : m_flags) | set_fl;
    end
    @(negedge clk);
    chk("flags", flags, m_flags);
  endtask

  task automatic idle(input logic ordy);
    step(1'b0, 16'h0000, 16'h0000, 4'h0, ordy, 1'b0, 1'b0);
  endtask

  task automatic directed(input string nm, input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] want_p, input logic [3:0] want_fl);
    int lat;
    step(1'b0, 16'h0000, 16'h0000, 4'h0, 1'b1, 1'b1, 1'b0);
    step(1'b1, a, b, 4'hA, 1'b1, 1'b0, 1'b0);
    lat = 1;
    while (out_valid !== 1'b1 && lat < 10) begin
      idle(1'b1);
      lat++;
    end
    chk({nm, "_latency"}, lat, 3);
    chk({nm, "_p"}, out_p, want_p);
    idle(1'b1);
    chk({nm, "_flags"}, flags, want_fl);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int lat;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_tag    = '0;
    out_ready = 1'b0;
    clr_flags = 1'b0;
    @(negedge clk);
    step(1'b0, 16'h0000, 16'h0000, 4'h0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 16'h0000, 16'h0000, 4'h0, 1'b0, 1'b0, 1'b1);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_p", out_p, 16'h0000);
    chk("rst_out_tag", out_tag, 4'h0);
    chk("rst_flags", flags, 4'b0000);
    chk("rst_in_ready", in_ready, 1'b1);

    directed("one_x_two",  16'h3F80, 16'h4000, 16'h4000, 4'b0000);
    directed("round_3fc1", 16'h3FC1, 16'h3FC1, EXP_3FC1_SQ, 4'b0001);
    directed("round_carry", 16'h3FB5, 16'h3FB5, EXP_3FB5_SQ, 4'b0001);
    directed("overflow",   16'h7F00, 16'h4000, 16'h7F80, 4'b0101);
    directed("max_normal", 16'h7F00, 16'h3F80, 16'h7F00, 4'b0000);
    directed("underflow",  16'h0080, 16'h0080, 16'h0000, 4'b0011);
    directed("unf_edge",   16'h0080, 16'h3F00, 16'h0000, 4'b0011);
    directed("min_normal", 16'h0080, 16'h3F80, 16'h0080, 4'b0000);
    directed("inf_x_zero", 16'h7F80, 16'h0000, 16'h7FC0, 4'b1000);
    directed("nan_in",     16'hFFC0, 16'h3F80, 16'h7FC0, 4'b0000);
    directed("neg_zero",   16'h8000, 16'h3F80, 16'h8000, 4'b0000);
    directed("neg_inf",    16'hFF80, 16'h4000, 16'hFF80, 4'b0000);

    // Stall: three accepts, then the output holds until released.
    for (int i = 1; i <= 3; i++) begin
      chk("stall_accept_rdy", in_ready, 1'b1);
      step(1'b1, 16'h3F80 + 16'(i), 16'h4000, 4'(i), 1'b0, 1'b0, 1'b0);
    end
    chk("stall_rdy_drop", in_ready, 1'b0);
    chk("stall_out_vld", out_valid, 1'b1);
    for (int i = 0; i < 2; i++) begin
      step(1'b1, 16'h3F80, 16'h3F80, 4'hF, 1'b0, 1'b0, 1'b0);
      if (sb_q.size() > 0) chk("stall_hold_p", out_p, sb_q[0].p);
      chk("stall_hold_tag", out_tag, 4'h1);
    end
    for (int i = 1; i <= 3; i++) begin
      chk("release_tag_order", out_tag, 4'(i));
      idle(1'b1);
    end
    chk("release_rdy_back", in_ready, 1'b1);
    chk("release_empty", out_valid, 1'b0);

    // Reset with work in flight, then clear racing a flag set.
    directed("pre_rst_inv", 16'h7F80, 16'h0000, 16'h7FC0, 4'b1000);
    step(1'b1, 16'h3F80, 16'h4000, 4'h5, 1'b1, 1'b0, 1'b0);
    step(1'b1, 16'h4000, 16'h4000, 4'h6, 1'b1, 1'b0, 1'b0);
    step(1'b0, 16'h0000, 16'h0000, 4'h0, 1'b1, 1'b0, 1'b1);
    chk("midrst_out_valid", out_valid, 1'b0);
    chk("midrst_flags", flags, 4'b0000);
    step(1'b1, 16'h7F00, 16'h4000, 4'h7, 1'b1, 1'b0, 1'b0);
    lat = 1;
    while (out_valid !== 1'b1 && lat < 10) begin
      idle(1'b1);
      lat++;
    end
    chk("postrst_latency", lat, 3);
    step(1'b0, 16'h0000, 16'h0000, 4'h0, 1'b1, 1'b1, 1'b0);
    chk("clr_vs_set", flags, 4'b0101);

    for (int i = 0; i < 500; i++) begin
      step(($urandom % 4) != 0, gen_op(), gen_op(), 4'($urandom),
           ($urandom % 4) != 0, ($urandom % 16) == 0, 1'b0);
    end
    for (int i = 0; i < 50 && sb_q.size() > 0; i++) idle(1'b1);
    chk("drain_empty", sb_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
